// File: rtl/sd_ctrl_pkg.sv
// Shared types and helpers for the SD card bring-up / block-read sequencer.
package sd_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD0, S_CMD8, S_ACMD41, S_GAP, S_CMD2, S_CMD3, S_CMD7,
    S_SET_BLK, S_READY, S_READ, S_RESIZE, S_ERROR
  } sd_state_e;

  typedef enum logic { PH_ISSUE, PH_WAIT } sd_phase_e;

  localparam logic [3:0] E_NONE    = 4'd0;
  localparam logic [3:0] E_CMD0    = 4'd1;
  localparam logic [3:0] E_CMD8    = 4'd2;
  localparam logic [3:0] E_ACMD41  = 4'd3;
  localparam logic [3:0] E_CMD2    = 4'd4;
  localparam logic [3:0] E_CMD3    = 4'd5;
  localparam logic [3:0] E_CMD7    = 4'd6;
  localparam logic [3:0] E_SET_BLK = 4'd7;
  localparam logic [3:0] E_READ    = 4'd8;
  localparam logic [3:0] E_NOCARD  = 4'd9;
  localparam logic [3:0] E_TIMEOUT = 4'd10;

  localparam int HDR_BLOCK_DEF = 54;

  // Strobe vector order: cmd0, cmd8, acmd41, cmd2, cmd3, cmd7, change_size, read
  function automatic logic [7:0] strobe_of(sd_state_e s, sd_phase_e p);
    logic [7:0] v;
    v = '0;
    if (p == PH_ISSUE) begin
      case (s)
        S_CMD0:             v[0] = 1'b1;
        S_CMD8:             v[1] = 1'b1;
        S_ACMD41:           v[2] = 1'b1;
        S_CMD2:             v[3] = 1'b1;
        S_CMD3:             v[4] = 1'b1;
        S_CMD7:             v[5] = 1'b1;
        S_SET_BLK, S_RESIZE: v[6] = 1'b1;
        S_READ:             v[7] = 1'b1;
        default:            v = '0;
      endcase
    end
    return v;
  endfunction

  function automatic logic is_cmd(sd_state_e s);
    return s inside {S_CMD0, S_CMD8, S_ACMD41, S_CMD2, S_CMD3, S_CMD7,
                     S_SET_BLK, S_READ, S_RESIZE};
  endfunction

  function automatic sd_state_e next_ok(sd_state_e s);
    case (s)
      S_CMD0:   return S_CMD8;
      S_CMD8:   return S_ACMD41;
      S_ACMD41: return S_CMD2;
      S_CMD2:   return S_CMD3;
      S_CMD3:   return S_CMD7;
      S_CMD7:   return S_SET_BLK;
      S_SET_BLK, S_READ, S_RESIZE: return S_READY;
      default:  return S_ERROR;
    endcase
  endfunction

  function automatic logic [3:0] fail_code(sd_state_e s);
    case (s)
      S_CMD0:   return E_CMD0;
      S_CMD8:   return E_CMD8;
      S_ACMD41: return E_ACMD41;
      S_CMD2:   return E_CMD2;
      S_CMD3:   return E_CMD3;
      S_CMD7:   return E_CMD7;
      S_SET_BLK, S_RESIZE: return E_SET_BLK;
      S_READ:   return E_READ;
      default:  return E_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sd_cmd_timer.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
module sd_cmd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/sd_init_sequencer.sv
// SD card bring-up and single-block read/resize sequencer.
// Optional per-command watchdog enabled by defining SDC_TIMEOUT_EN.
module sd_init_sequencer
  import sd_ctrl_pkg::*;
#(
  parameter int ACMD41_RETRIES = 16,
  parameter int RETRY_GAP      = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int HDR_BLOCK      = HDR_BLOCK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        card_detect,
  input  logic        if_hold,
  input  logic        if_error,
  output logic        cmd0_o,
  output logic        cmd8_o,
  output logic        acmd41_o,
  output logic        cmd2_o,
  output logic        cmd3_o,
  output logic        cmd7_o,
  output logic        change_size_o,
  output logic        read_o,
  output logic [31:0] block_size,
  output logic [31:0] r_address,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ack,
  input  logic        sz_req,
  input  logic [31:0] sz_val,
  output logic        sz_ack,
  output logic        ready,
  output logic        error,
  output logic [3:0]  err_code
);

  localparam int TRY_W = $clog2(ACMD41_RETRIES + 1);
  localparam int GAP_W = $clog2(RETRY_GAP + 1);

  sd_state_e        state, state_n;
  sd_phase_e        phase, phase_n;
  logic [3:0]       err_n;
  logic [TRY_W-1:0] tries;
  logic [7:0]       strb;
  logic             acmd_fail, rd_acc, sz_acc;
  logic             gap_load, gap_exp;

  assign gap_load = (state_n == S_GAP) && (state != S_GAP);

  sd_cmd_timer #(.W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_W'(RETRY_GAP - 1)),
    .expired  (gap_exp)
  );

`ifdef SDC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic wd_load, wd_exp;

  // Reloaded whenever a different command state is entered, so each command gets a fresh budget.
  assign wd_load = is_cmd(state_n) && (state_n != state);

  sd_cmd_timer #(.W(WD_W)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load),
    .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
    .expired  (wd_exp)
  );
`endif

  always_comb begin
    state_n   = state;
    phase_n   = phase;
    err_n     = err_code;
    acmd_fail = 1'b0;
    rd_acc    = 1'b0;
    sz_acc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (card_detect) state_n = S_CMD0;
          else begin
            state_n = S_ERROR;
            err_n   = E_NOCARD;
          end
        end
      end
      S_ERROR: begin
        if (start && card_detect) begin
          state_n = S_CMD0;
          err_n   = E_NONE;
        end
      end
      S_GAP: if (gap_exp) state_n = S_ACMD41;
      S_READY: begin
        // The ack cycle never accepts, so a requester still holding its level sees the ack first.
        if (!rd_ack && !sz_ack) begin
          if (sz_req) begin
            state_n = S_RESIZE;
            sz_acc  = 1'b1;
          end else if (rd_req) begin
            state_n = S_READ;
            rd_acc  = 1'b1;
          end
        end
      end
      default: begin
        if (phase == PH_ISSUE) begin
          if (if_hold) phase_n = PH_WAIT;
        end else if (!if_hold) begin
          if (!if_error) state_n = next_ok(state);
          else if (state == S_ACMD41 && int'(tries) < ACMD41_RETRIES - 1) begin
            state_n   = S_GAP;
            acmd_fail = 1'b1;
          end else begin
            state_n = S_ERROR;
            err_n   = fail_code(state);
          end
        end
      end
    endcase
`ifdef SDC_TIMEOUT_EN
    if (is_cmd(state) && wd_exp) begin
      state_n   = S_ERROR;
      err_n     = E_TIMEOUT;
      acmd_fail = 1'b0;
    end
`endif
    if (!card_detect && state != S_IDLE && state != S_ERROR) begin
      state_n   = S_ERROR;
      err_n     = E_NOCARD;
      acmd_fail = 1'b0;
      rd_acc    = 1'b0;
      sz_acc    = 1'b0;
    end
    if (state_n != state) phase_n = PH_ISSUE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= PH_ISSUE;
      err_code   <= E_NONE;
      tries      <= '0;
      strb       <= '0;
      block_size <= 32'(HDR_BLOCK);
      r_address  <= '0;
      rd_ack     <= 1'b0;
      sz_ack     <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      err_code <= err_n;
      strb     <= strobe_of(state_n, phase_n);
      rd_ack   <= (state == S_READ)   && (state_n == S_READY);
      sz_ack   <= (state == S_RESIZE) && (state_n == S_READY);
      if (rd_acc) r_address <= rd_addr;
      if (sz_acc) block_size <= sz_val;
      else if (state_n == S_SET_BLK && state != S_SET_BLK) block_size <= 32'(HDR_BLOCK);
      if (state != S_ACMD41 && state != S_GAP) tries <= '0;
      else if (acmd_fail)                      tries <= tries + 1'b1;
    end
  end

  assign {read_o, change_size_o, cmd7_o, cmd3_o, cmd2_o, acmd41_o, cmd8_o, cmd0_o} = strb;
  assign ready = (state == S_READY);
  assign error = (state == S_ERROR);

endmodule
